// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and helpers for the streaming NTT pointwise blocks.
//   coeff_t          - one coefficient word (default 32-bit datapath)
//   pw_mode_e        - pointwise operation: PW_MUL (a*b) or PW_MAC (a*b+d)
//   beats_per_frame  - number of LANES-wide beats in an N-coefficient frame
package ntt_pkg;

  localparam int NTT_WIDTH = 32;

  typedef logic [NTT_WIDTH-1:0] coeff_t;

  typedef enum logic {
    PW_MUL = 1'b0,
    PW_MAC = 1'b1
  } pw_mode_e;

  function automatic int beats_per_frame(input int n, input int lanes);
    return n / lanes;
  endfunction

endpackage

// File: rtl/ntt_pw_lane.sv
// ntt_pw_lane: two-stage modular multiply / multiply-accumulate for one lane.
//   S1 registers the full 2*WIDTH product a*b, the addend d and the mode.
//   S2 registers (p mod Q) + (d mod Q in MAC), brought back below Q.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   en        - shared pipeline enable; both stages hold when low
//   mode      - operation for the beat presented on a/b/d
//   a, b, d   - operands (any value, reduced internally)
//   c         - registered result, always < Q
module ntt_pw_lane
  import ntt_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int Q     = 3329
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  pw_mode_e         mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c
);

  localparam logic [2*WIDTH-1:0] Q_WIDE = (2*WIDTH)'(Q);
  localparam logic [WIDTH-1:0]   Q_W    = WIDTH'(Q);
  localparam logic [WIDTH:0]     Q_SUM  = (WIDTH+1)'(Q);

  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   d_reg;
  pw_mode_e           mode_reg;
  logic [WIDTH-1:0]   c_reg;

  logic [2*WIDTH-1:0] p_mod;
  logic [WIDTH-1:0]   d_mod;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     sum_red;
  logic               unused_p_hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg <= '0;
      d_reg    <= '0;
      mode_reg <= PW_MUL;
      c_reg    <= '0;
    end else if (en) begin
      prod_reg <= {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      d_reg    <= d;
      mode_reg <= mode;
      c_reg    <= sum_red[WIDTH-1:0];
    end
  end

  // Both residues are < Q, so their sum is < 2Q and one subtract suffices.
  always_comb begin
    p_mod   = prod_reg % Q_WIDE;
    d_mod   = d_reg % Q_W;
    sum     = {1'b0, p_mod[WIDTH-1:0]} +
              ((mode_reg == PW_MAC) ? {1'b0, d_mod} : '0);
    sum_red = (sum >= Q_SUM) ? (sum - Q_SUM) : sum;
  end

  // p mod Q < Q < 2**WIDTH, so the upper half of the residue is always zero.
  assign unused_p_hi = ^p_mod[2*WIDTH-1:WIDTH];

  assign c = c_reg;

endmodule

// File: rtl/ntt_pointwise_stream.sv
// ntt_pointwise_stream: streaming pointwise multiplier for NTT-domain frames.
// One frame of N coefficients arrives as N/LANES beats of LANES lanes.
//   MUL: C[i] = A[i]*B[i] mod Q      MAC: C[i] = (A[i]*B[i] + D[i]) mod Q
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   mode                - 0=MUL 1=MAC, latched on beat 0 of each frame
//   in_valid/in_ready   - input handshake; in_a/in_b/in_d lane-packed operands
//   in_last             - sender's end-of-frame marker (checked, not trusted)
//   out_valid/out_ready - output handshake; out_c lane-packed results < Q
//   out_last, out_idx   - beat position of out_c, from the internal counter
//   frame_err           - sticky: in_last disagreed with the beat counter
//   range_err           - sticky operand >= Q flag
// Optional build macro: NTT_PW_RANGE_CHECK_EN enables the range_err compare
// logic; without it range_err is tied low.
module ntt_pointwise_stream
  import ntt_pkg::*;
#(
  parameter int    N     = 256,
  parameter int    WIDTH = 32,
  parameter int    Q     = 3329,
  parameter int    LANES = 4,
  localparam int   BEATS = beats_per_frame(N, LANES),
  localparam int   IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [LANES*WIDTH-1:0] in_d,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_c,
  output logic                   out_last,
  output logic [IDXW-1:0]        out_idx,
  output logic                   frame_err,
  output logic                   range_err
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BEATS - 1);

  logic            en;
  logic            accept;
  logic [IDXW-1:0] cnt_reg;
  logic            cnt_is_last;
  pw_mode_e        mode_reg;
  pw_mode_e        beat_mode;

  logic            s1_valid;
  logic [IDXW-1:0] s1_idx;
  logic            s1_last;
  logic            s2_valid;
  logic [IDXW-1:0] s2_idx;
  logic            s2_last;
  logic            frame_err_reg;

  // The whole pipeline advances unless a finished beat is waiting downstream.
  assign en          = !(s2_valid && !out_ready);
  assign in_ready    = en && !rst;
  assign accept      = in_valid && in_ready;
  assign cnt_is_last = (cnt_reg == LAST_IDX);

  // Beat 0 uses the live mode input; later beats use the value latched there.
  assign beat_mode = (cnt_reg == '0) ? pw_mode_e'(mode) : mode_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      mode_reg <= PW_MUL;
    end else if (accept) begin
      cnt_reg <= cnt_is_last ? '0 : cnt_reg + 1'b1;
      if (cnt_reg == '0) begin
        mode_reg <= pw_mode_e'(mode);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_idx   <= '0;
      s2_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= accept;
      s1_idx   <= cnt_reg;
      s1_last  <= cnt_is_last;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
      s2_last  <= s1_last;
    end
  end

  // The counter keeps its own sequence; in_last is only compared against it.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
    end else if (accept && (in_last != cnt_is_last)) begin
      frame_err_reg <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      ntt_pw_lane #(
        .WIDTH (WIDTH),
        .Q     (Q)
      ) u_lane (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (beat_mode),
        .a    (in_a[gi*WIDTH +: WIDTH]),
        .b    (in_b[gi*WIDTH +: WIDTH]),
        .d    (in_d[gi*WIDTH +: WIDTH]),
        .c    (out_c[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

`ifdef NTT_PW_RANGE_CHECK_EN
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  logic [LANES-1:0] lane_oor;
  logic             range_err_reg;

  generate
    for (gi = 0; gi < LANES; gi++) begin : g_range
      assign lane_oor[gi] = (in_a[gi*WIDTH +: WIDTH] >= Q_W) ||
                            (in_b[gi*WIDTH +: WIDTH] >= Q_W) ||
                            ((beat_mode == PW_MAC) &&
                             (in_d[gi*WIDTH +: WIDTH] >= Q_W));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      range_err_reg <= 1'b0;
    end else if (accept && (|lane_oor)) begin
      range_err_reg <= 1'b1;
    end
  end

  assign range_err = range_err_reg;
`else
  assign range_err = 1'b0;
`endif

  assign out_valid = s2_valid;
  assign out_idx   = s2_idx;
  assign out_last  = s2_last;
  assign frame_err = frame_err_reg;

endmodule

// File: doc/ntt_pointwise_stream.md
Name: ntt_pointwise_stream

Overview:
Streaming, pipelined successor to the fully parallel pointwise multiplier. It processes one NTT-domain coefficient frame of N entries at LANES coefficients per beat, using valid/ready handshakes on input and output. Two modes: MUL computes C[i] = A[i]*B[i] mod Q; MAC computes C[i] = (A[i]*B[i] + D[i]) mod Q. It sits between the coefficient RAM readers and the INTT feeder, replacing N parallel multipliers with LANES pipelined ones.

Parameters:
N, 256, coefficients per frame; must be a multiple of LANES
WIDTH, 32, coefficient bit width; Q < 2**WIDTH
Q, 3329, modulus
LANES, 4, coefficients processed per beat (power of two, 1..N)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
mode  input  1  0=MUL, 1=MAC; sampled on the first beat of each frame
in_valid  input  1  input beat valid
in_ready  output  1  block accepts beat when in_valid && in_ready
in_a  input  LANES x WIDTH  operand A lanes, lane k = coefficient beat*LANES+k
in_b  input  LANES x WIDTH  operand B lanes
in_d  input  LANES x WIDTH  accumulate operand (ignored in MUL)
in_last  input  1  marks the final beat of a frame
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts when out_valid && out_ready
out_c  output  LANES x WIDTH  result lanes, each < Q
out_last  output  1  final beat of frame, regenerated from the beat counter
out_idx  output  log2(N/LANES)  beat index of out_c within the frame
frame_err  output  1  sticky: in_last disagreed with the beat counter
range_err  output  1  sticky operand range flag (see Optional Feature)

Behaviour:
- Reset: in_ready=0 for the reset cycle only. out_valid=0, out_c=0, out_last=0, out_idx=0, frame_err=0, range_err=0. Input beat counter=0, latched mode=MUL. Pipeline valids cleared. Reset mid-frame discards all in-flight beats; the next accepted beat starts a new frame.
- Pipeline: 2 stages. S1 registers the full 2*WIDTH product a*b, plus d and the mode. S2 registers (p mod Q), then adds d mod Q in MAC, with a conditional subtract so the result is < Q. Latency is 2 cycles from input accept to out_valid with no stall.
- Stall: en = !(s2_valid && !out_ready), and in_ready = en. With out_ready held high, throughput is 1 beat/cycle. When stalled, all stage registers hold. No bubbles are inserted and no data is dropped or duplicated.
- Input beat counter: counts 0..N/LANES-1 on each accept.
  - Count 0 latches mode for the whole frame; mode changes mid-frame are ignored.
  - Wraps to 0 after N/LANES-1.
  - If in_last=1 at a count other than N/LANES-1, or in_last=0 at N/LANES-1, frame_err is set. The counter still follows its own sequence and does not resync to in_last.
- out_idx and out_last travel with the beat through the pipeline. out_last=1 exactly when out_idx=N/LANES-1.
- Operands >= Q are reduced as given, because the full product is taken mod Q. d >= Q is also reduced mod Q. Outputs are always in [0,Q-1].
- Back-to-back frames: the beat at count 0 of frame k+1 may be accepted in the cycle after the last beat of frame k, with no idle cycle.
- frame_err and range_err clear only on rst.

Optional Feature:
NTT_PW_RANGE_CHECK_EN
- Defined: range_err is set (sticky) when any accepted lane has in_a>=Q or in_b>=Q, or in_d>=Q in MAC mode. The data result is unchanged.
- Undefined: range_err is tied 0 and no compare logic is built.

Decomposition:
- Shared package ntt_pkg:
  - typedef coeff_t (logic [WIDTH-1:0])
  - enum pw_mode_e {PW_MUL=0, PW_MAC=1}
  - function beats_per_frame(N,LANES)
- One sub-module, ntt_pw_lane: the 2-stage multiply/reduce/accumulate datapath for one lane, sharing a common enable. It is instantiated LANES times by generate. Counters, handshake and flags stay in the top module.

Test Plan:
- MUL, Q=3329, out_ready=1, lane0 a=3000 b=3000 -> out_c[0]=1713 two cycles after accept, out_idx=0.
- MAC, a=3000 b=3000 d=3328 -> out_c=1712. Also a=0 b=5 d=7 -> 7.
- Full frame of 64 beats (N=256, LANES=4), a=i, b=1 -> out_c lane k = 4*beat+k. out_last only on beat 63. No gaps, and a second frame follows immediately.
- Random out_ready backpressure (50%) over 3 frames -> output sequence matches the model exactly, in_ready falls within the same cycle as the stall, no loss or duplication.
- in_last asserted on beat 10 -> frame_err=1 and stays set. out_last still appears on out_idx 63. Reset applied at beat 30 mid-frame -> out_valid=0, a new frame starts at out_idx 0, and frame_err is cleared.
- With NTT_PW_RANGE_CHECK_EN, a=3329 b=2 -> range_err=1 and out_c=0. Without the macro -> range_err stays 0.
